freq_detect_mc: RTL and testbench
=================================

# freq_detect_mc

Multi-channel, auto-ranging frequency detector. A single instance measures up to `CH` test signals in sequence against per-sweep bounds. Each test signal arrives as a one-cycle pulse per test-clock edge, already synchronised into the reference domain by the per-channel front end. For each channel the block counts pulses over a window of `FullScale` reference cycles. When a result lands exactly on a bound it doubles the window and re-measures. It reports per-channel result, warning and stuck status, and pulses a sweep-done strobe.

## Interface
- `WIDTH`, 16: width of window, bounds, magnify and result.
- `CH`, 4: number of test channels (1..16).
- `IDX_W`, `$clog2(CH)` (min 1): channel index width.
- `Clk_ref_i` in 1: reference clock. The single clock of the block.
- `Rst_n_i` in 1: reset, asynchronous, active-low.
- One clock; reset is asynchronous and active-low.
- `Start_i` in 1: level input. A rising edge starts a sweep.
- `Ch_en_i` in CH: channel enables, latched at sweep start.
- `Test_pulse_i` in CH: per-channel edge pulses.
- `FullScaleInitial`, `LowerBoundInitial`, `UpperBoundInitial` in 5 each: base window and bounds.
- `MagnifyInitial` in 11: starting magnify, loaded per channel.
- `MagnifyUpperLimit` in 5: magnify ceiling, scaled by <<10.
- `Busy_o` out 1: sweep in progress.
- `Finish_o` out 1: one-cycle pulse at sweep end.
- `Ch_valid_o` out 1: one-cycle pulse, per-channel result valid.
- `Ch_idx_o` out IDX_W: channel of the current result.
- `Ch_result_o` out WIDTH: final pulse count.
- `Ch_fullscale_o` out WIDTH: window used for the final count.
- `Ch_warning_o` out CH: sticky per-channel warning flags.
- `Ch_stuck_o` out CH: sticky per-channel stuck flags.

## Operation
- FSM states:
  - IDLE: on a `Start_i` rising edge, latch `Ch_en_i` and clear `Ch_warning_o`/`Ch_stuck_o`. Go to SELECT.
  - SELECT: pick the lowest enabled, not-yet-done channel. Load Magnify = MagnifyInitial (zero-extended) and go to PREPARE. If no channel remains, pulse `Finish_o` and go to IDLE.
  - PREPARE: compute FullScale = Magnify*FullScaleInitial, Upper = Magnify*UpperBoundInitial and Lower = Magnify*LowerBoundInitial, each truncated to WIDTH. Clear the window and pulse counters. Go to COUNT.
  - COUNT: count `Test_pulse_i[sel]` for max(FullScale,1) cycles. The pulse counter saturates at all-ones. Go to DETECT.
  - DETECT: if (result==Upper or result==Lower) and Magnify < (MagnifyUpperLimit<<10), then Magnify <<= 1 and go to PREPARE. Otherwise go to REPORT.
  - REPORT: pulse `Ch_valid_o` with idx, result and fullscale. Set warning[sel] if result>Upper, result<Lower, or Magnify >= limit. Set stuck[sel] if result <= (Lower>>3)+1. Mark the channel done and go to SELECT.
- Reset values: all outputs 0; FSM in IDLE; Magnify 1.
- `Start_i` edges while Busy are ignored. Busy_o is high in every state except IDLE.
- `Ch_en_i` changes during a sweep have no effect.
- All-zero enables: SELECT finishes immediately. `Finish_o` pulses with no `Ch_valid_o`.
- Reset mid-sweep aborts immediately. All flags clear and no `Finish_o` is produced.
- `Ch_result_o`/`Ch_fullscale_o`/`Ch_idx_o` hold their values until the next REPORT.

## Timing
- The rising edge of `Start_i` is registered internally. SELECT is entered 1 cycle after the edge is sampled.
- Per measurement attempt: PREPARE 1 cycle, COUNT max(FS,1) cycles, DETECT 1 cycle.
- Per channel: SELECT 1 cycle plus N attempts plus REPORT 1 cycle.
- A pulse counts if it is high in any COUNT cycle of the selected channel. Pulses during PREPARE/DETECT are dropped.
- `Ch_valid_o` is high during REPORT. Flags update on the same edge that asserts `Ch_valid_o`.
- `Finish_o` is high for exactly the one cycle in which SELECT finds no remaining channel.

## Configuration
- `FREQ_DETECT_MC_STUCK_EN`:
  - Defined: stuck comparison and `Ch_stuck_o` flag registers are built as described.
  - Undefined: `Ch_stuck_o` is tied to 0 and no comparator is synthesised. All other behaviour is identical.

## Structure
- Shared package `freq_detect_pkg` holds:
  - the FSM state enum;
  - the `MAG_SHIFT`=10 constant;
  - the 5-bit and 11-bit initial-field widths.
- One sub-module, `freq_window_counter`. It holds the window countdown and the saturating pulse counter, with start/done handshake, mux-selected input and `WIDTH`-parametrised.
- Channel selection is a priority pick over `en_latched & ~done`.

## Test plan
1. CH=4, Ch_en=4'b0001, FSI=16, LBI=5, UBI=15, MI=1, MUL=1; ch0 pulses every 2nd cycle -> one `Ch_valid_o`, idx0, result 8, fullscale 16, warning 0, stuck 0, then `Finish_o`.
2. Same config, ch0 pulses every cycle -> result 16, warning[0]=1, stuck[0]=0.
3. Same config, ch0 gets exactly 5 pulses in the first window, then pulses every 2nd cycle -> re-range. Report shows fullscale 32, result 16, warning 0.
4. MI=1024, MUL=1, ch0 result equal to Upper -> no re-range (Magnify==limit). warning[0]=1, fullscale 16384.
5. Ch_en=4'b1010, ch1 silent, ch3 pulses every 2nd cycle:
   - `Ch_valid_o` for idx1 first: result 0, stuck[1]=1, warning[1]=1.
   - Then idx3: result 8.
   - Then `Finish_o`.
6. Ch_en=0 -> `Finish_o` 2 cycles after the Start edge with no `Ch_valid_o`. Rst_n_i low mid-COUNT -> all outputs 0 and no `Finish_o`.

Source files
------------

// File: rtl/freq_detect_pkg.sv
// Shared types and constants for the multi-channel frequency detector.
package freq_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PREPARE,
    ST_COUNT,
    ST_DETECT,
    ST_REPORT
  } state_e;

  localparam int unsigned MAG_SHIFT  = 10;
  localparam int unsigned INIT_W     = 5;
  localparam int unsigned MAG_INIT_W = 11;

endpackage

// File: rtl/freq_detect_mc_if.sv
// Sweep control and per-channel report bus of freq_detect_mc.
interface freq_detect_mc_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1
);
  logic             Start_i;
  logic [CH-1:0]    Ch_en_i;
  logic             Busy_o;
  logic             Finish_o;
  logic             Ch_valid_o;
  logic [IDX_W-1:0] Ch_idx_o;
  logic [WIDTH-1:0] Ch_result_o;
  logic [WIDTH-1:0] Ch_fullscale_o;
  logic [CH-1:0]    Ch_warning_o;
  logic [CH-1:0]    Ch_stuck_o;

  modport master (
    output Start_i, Ch_en_i,
    input  Busy_o, Finish_o, Ch_valid_o, Ch_idx_o, Ch_result_o,
           Ch_fullscale_o, Ch_warning_o, Ch_stuck_o
  );

  modport slave (
    input  Start_i, Ch_en_i,
    output Busy_o, Finish_o, Ch_valid_o, Ch_idx_o, Ch_result_o,
           Ch_fullscale_o, Ch_warning_o, Ch_stuck_o
  );
endinterface

// File: rtl/freq_window_counter.sv
// Window countdown plus saturating pulse counter on the selected channel.
module freq_window_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] fullscale_i,
  input  logic [CH-1:0]    pulse_i,
  input  logic [IDX_W-1:0] sel_i,
  output logic             done_o,
  output logic [WIDTH-1:0] count_o
);

  logic             active_q, active_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pulse;

  assign pulse = pulse_i[sel_i];

  always_comb begin
    active_d = active_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      // A zero-length window still measures for one cycle.
      remain_d = (fullscale_i == '0) ? WIDTH'(1) : fullscale_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (pulse && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
      if (remain_q == WIDTH'(1)) active_d = 1'b0;
      else                       remain_d = remain_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      remain_q <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done_o  = active_q && (remain_q == WIDTH'(1));
  assign count_o = cnt_q;

endmodule

// File: rtl/freq_detect_mc.sv
// Multi-channel auto-ranging frequency detector (sweep FSM + window counter).
// Optional build macro FREQ_DETECT_MC_STUCK_EN enables the stuck-channel flags.
module freq_detect_mc
  import freq_detect_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH    = 4,
  parameter int unsigned IDX_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  Clk_ref_i,
  input  logic                  Rst_n_i,
  input  logic [CH-1:0]         Test_pulse_i,
  input  logic [INIT_W-1:0]     FullScaleInitial,
  input  logic [INIT_W-1:0]     LowerBoundInitial,
  input  logic [INIT_W-1:0]     UpperBoundInitial,
  input  logic [MAG_INIT_W-1:0] MagnifyInitial,
  input  logic [INIT_W-1:0]     MagnifyUpperLimit,
  freq_detect_mc_if.slave       bus
);

  state_e           state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic             rise_q, rise_d;
  logic [CH-1:0]    en_q, en_d;
  logic [CH-1:0]    done_q, done_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] magnify_q, magnify_d;
  logic [WIDTH-1:0] fs_q, fs_d;
  logic [WIDTH-1:0] up_q, up_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] fs_out_q, fs_out_d;
  logic [CH-1:0]    warn_q, warn_d;
`ifdef FREQ_DETECT_MC_STUCK_EN
  logic [CH-1:0]    stuck_q, stuck_d;
`endif

  logic [CH-1:0]    pending;
  logic [IDX_W-1:0] pick;
  logic [WIDTH-1:0] prod_fs, prod_up, prod_lo;
  logic [31:0]      limit;
  logic             below_limit;
  logic             cnt_start;
  logic             cnt_done;
  logic [WIDTH-1:0] cnt;

  assign prod_fs     = magnify_q * WIDTH'(FullScaleInitial);
  assign prod_up     = magnify_q * WIDTH'(UpperBoundInitial);
  assign prod_lo     = magnify_q * WIDTH'(LowerBoundInitial);
  assign limit       = 32'(MagnifyUpperLimit) << MAG_SHIFT;
  assign below_limit = 32'(magnify_q) < limit;
  assign pending     = en_q & ~done_q;
  assign cnt_start   = (state_q == ST_PREPARE);

  always_comb begin
    pick = '0;
    for (int unsigned i = CH; i > 0; i--) begin
      if (pending[i-1]) pick = IDX_W'(i - 1);
    end
  end

  freq_window_counter #(
    .WIDTH (WIDTH),
    .CH    (CH),
    .IDX_W (IDX_W)
  ) u_win (
    .clk_i       (Clk_ref_i),
    .rst_ni      (Rst_n_i),
    .start_i     (cnt_start),
    .fullscale_i (prod_fs),
    .pulse_i     (Test_pulse_i),
    .sel_i       (sel_q),
    .done_o      (cnt_done),
    .count_o     (cnt)
  );

  always_comb begin
    state_d      = state_q;
    start_prev_d = bus.Start_i;
    rise_d       = bus.Start_i & ~start_prev_q;
    en_d         = en_q;
    done_d       = done_q;
    sel_d        = sel_q;
    magnify_d    = magnify_q;
    fs_d         = fs_q;
    up_d         = up_q;
    lo_d         = lo_q;
    finish_d     = 1'b0;
    valid_d      = 1'b0;
    idx_d        = idx_q;
    result_d     = result_q;
    fs_out_d     = fs_out_q;
    warn_d       = warn_q;
`ifdef FREQ_DETECT_MC_STUCK_EN
    stuck_d      = stuck_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rise_q) begin
          en_d    = bus.Ch_en_i;
          done_d  = '0;
          warn_d  = '0;
`ifdef FREQ_DETECT_MC_STUCK_EN
          stuck_d = '0;
`endif
          state_d = ST_SELECT;
          // Finish is registered, so it is decided on the edge entering SELECT.
          finish_d = (bus.Ch_en_i == '0);
        end
      end
      ST_SELECT: begin
        if (pending != '0) begin
          sel_d     = pick;
          magnify_d = WIDTH'(MagnifyInitial);
          state_d   = ST_PREPARE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREPARE: begin
        fs_d    = prod_fs;
        up_d    = prod_up;
        lo_d    = prod_lo;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (cnt_done) state_d = ST_DETECT;
      end
      ST_DETECT: begin
        if (((cnt == up_q) || (cnt == lo_q)) && below_limit) begin
          magnify_d = magnify_q << 1;
          state_d   = ST_PREPARE;
        end else begin
          valid_d       = 1'b1;
          idx_d         = sel_q;
          result_d      = cnt;
          fs_out_d      = fs_q;
          warn_d[sel_q] = warn_q[sel_q] | (cnt > up_q) | (cnt < lo_q) | ~below_limit;
`ifdef FREQ_DETECT_MC_STUCK_EN
          stuck_d[sel_q] = stuck_q[sel_q] | (cnt <= ((lo_q >> 3) + WIDTH'(1)));
`endif
          done_d[sel_q] = 1'b1;
          state_d       = ST_REPORT;
        end
      end
      ST_REPORT: begin
        state_d  = ST_SELECT;
        finish_d = (pending == '0);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk_ref_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      rise_q       <= 1'b0;
      en_q         <= '0;
      done_q       <= '0;
      sel_q        <= '0;
      magnify_q    <= WIDTH'(1);
      fs_q         <= '0;
      up_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      finish_q     <= 1'b0;
      valid_q      <= 1'b0;
      idx_q        <= '0;
      result_q     <= '0;
      fs_out_q     <= '0;
      warn_q       <= '0;
`ifdef FREQ_DETECT_MC_STUCK_EN
      stuck_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      rise_q       <= rise_d;
      en_q         <= en_d;
      done_q       <= done_d;
      sel_q        <= sel_d;
      magnify_q    <= magnify_d;
      fs_q         <= fs_d;
      up_q         <= up_d;
      lo_q         <= lo_d;
      busy_q       <= busy_d;
      finish_q     <= finish_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      fs_out_q     <= fs_out_d;
      warn_q       <= warn_d;
`ifdef FREQ_DETECT_MC_STUCK_EN
      stuck_q      <= stuck_d;
`endif
    end
  end

  assign bus.Busy_o         = busy_q;
  assign bus.Finish_o       = finish_q;
  assign bus.Ch_valid_o     = valid_q;
  assign bus.Ch_idx_o       = idx_q;
  assign bus.Ch_result_o    = result_q;
  assign bus.Ch_fullscale_o = fs_out_q;
  assign bus.Ch_warning_o   = warn_q;
`ifdef FREQ_DETECT_MC_STUCK_EN
  assign bus.Ch_stuck_o     = stuck_q;
`else
  assign bus.Ch_stuck_o     = '0;
`endif

endmodule

// File: tb/tb_freq_detect_mc.sv
// Table-driven, scoreboard-checked bench for freq_detect_mc.
module tb_freq_detect_mc;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CH    = 4;
  localparam int unsigned IDX_W = 2;
`ifdef FREQ_DETECT_MC_STUCK_EN
  localparam bit STUCK_ON = 1'b1;
`else
  localparam bit STUCK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] test_pulse;
  logic [4:0]    fsi, lbi, ubi, mul;
  logic [10:0]   mi;

  freq_detect_mc_if #(.WIDTH(WIDTH), .CH(CH), .IDX_W(IDX_W)) bus ();

  freq_detect_mc #(.WIDTH(WIDTH), .CH(CH), .IDX_W(IDX_W)) dut (
    .Clk_ref_i         (clk),
    .Rst_n_i           (rst_n),
    .Test_pulse_i      (test_pulse),
    .FullScaleInitial  (fsi),
    .LowerBoundInitial (lbi),
    .UpperBoundInitial (ubi),
    .MagnifyInitial    (mi),
    .MagnifyUpperLimit (mul),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {P_NONE, P_EVERY2, P_ALL, P_RERANGE, P_UPPER} pmode_e;

  typedef struct {
    logic [CH-1:0] ch_en;
    logic [CH-1:0] mask;
    pmode_e        mode;
    logic [10:0]   mi;
    logic [4:0]    mul;
  } vec_t;

  typedef struct {
    int               vid;
    bit               is_finish;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] fs;
    logic [CH-1:0]    warn;
    logic [CH-1:0]    stuck;
  } exp_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];
  exp_t reps [$];
  exp_t sb   [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [CH-1:0] st(logic [CH-1:0] s);
    return STUCK_ON ? s : '0;
  endfunction

  function automatic exp_t mk(int vid, bit fin, int idx, int res, int fs,
                              logic [CH-1:0] w, logic [CH-1:0] s);
    exp_t e;
    e.vid = vid; e.is_finish = fin; e.idx = IDX_W'(idx);
    e.result = WIDTH'(res); e.fs = WIDTH'(fs); e.warn = w; e.stuck = s;
    return e;
  endfunction

  function automatic bit pulse_on(pmode_e m, int c);
    case (m)
      P_EVERY2:  return (c % 2) == 0;
      P_ALL:     return 1'b1;
      P_RERANGE: return (c == 3 || c == 5 || c == 7 || c == 9 || c == 11) ||
                        (c >= 20 && (c % 2) == 0);
      P_UPPER:   return (c >= 3) && (c < 3 + 15360);
      default:   return 1'b0;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic on_valid();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_valid: got idx %0d result %0d expected no report",
               bus.Ch_idx_o, bus.Ch_result_o);
      return;
    end
    e = sb.pop_front();
    chk("valid_order", 1, e.is_finish ? 0 : 1);
    chk("idx", bus.Ch_idx_o, e.idx);
    chk("result", bus.Ch_result_o, e.result);
    chk("fullscale", bus.Ch_fullscale_o, e.fs);
    chk("warning", bus.Ch_warning_o, e.warn);
    chk("stuck", bus.Ch_stuck_o, e.stuck);
  endtask

  task automatic on_finish();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_finish: got finish expected none");
      return;
    end
    e = sb.pop_front();
    chk("finish_order", 1, e.is_finish ? 1 : 0);
    chk("finish_no_valid", bus.Ch_valid_o, 0);
    chk("finish_warning", bus.Ch_warning_o, e.warn);
    chk("finish_stuck", bus.Ch_stuck_o, e.stuck);
  endtask

  task automatic run_vector(int v);
    vec_t t;
    bit   done;
    t = vecs[v];
    mi = t.mi; mul = t.mul;
    bus.Start_i = 1'b0; bus.Ch_en_i = t.ch_en; test_pulse = '0;
    sb.delete();
    foreach (reps[i]) if (reps[i].vid == v) sb.push_back(reps[i]);
    repeat (2) @(negedge clk);
    bus.Start_i = 1'b1;
    done = 1'b0;
    for (int k = 1; k <= 20000 && !done; k++) begin
      @(negedge clk);
      if (bus.Ch_valid_o) on_valid();
      if (bus.Finish_o) begin
        on_finish();
        if (t.ch_en == '0) chk("finish_latency", k, 2);
        done = 1'b1;
      end
      if (k == 3 && t.ch_en != '0) chk("busy_mid", bus.Busy_o, 1);
      // A second Start edge mid-sweep and flipped enables must both be ignored.
      bus.Start_i = (k < 3) || (t.ch_en != '0 && k >= 6 && k < 8);
      bus.Ch_en_i = (k >= 2) ? ~t.ch_en : t.ch_en;
      test_pulse  = pulse_on(t.mode, k - 1) ? t.mask : '0;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout vec %0d: got no finish expected finish", v);
    end
    test_pulse = '0; bus.Start_i = 1'b0; bus.Ch_en_i = t.ch_en;
    @(negedge clk);
    chk("busy_after", bus.Busy_o, 0);
  endtask

  initial begin
    int seen;
    fsi = 5'd16; lbi = 5'd5; ubi = 5'd15; mi = 11'd1; mul = 5'd1;
    test_pulse = '0; bus.Start_i = 1'b0; bus.Ch_en_i = '0;

    vecs[0] = '{4'b0001, 4'b0001, P_EVERY2,  11'd1,    5'd1};
    vecs[1] = '{4'b0001, 4'b0001, P_ALL,     11'd1,    5'd1};
    vecs[2] = '{4'b0001, 4'b0001, P_RERANGE, 11'd1,    5'd1};
    vecs[3] = '{4'b0001, 4'b0001, P_UPPER,   11'd1024, 5'd1};
    vecs[4] = '{4'b1010, 4'b1000, P_EVERY2,  11'd1,    5'd1};
    vecs[5] = '{4'b0000, 4'b0000, P_NONE,    11'd1,    5'd1};
    vecs[6] = '{4'b1111, 4'b1111, P_ALL,     11'd1,    5'd1};

    reps.push_back(mk(0, 0, 0, 8,     16,    4'b0000, 4'b0000));
    reps.push_back(mk(0, 1, 0, 0,     0,     4'b0000, 4'b0000));
    reps.push_back(mk(1, 0, 0, 16,    16,    4'b0001, 4'b0000));
    reps.push_back(mk(1, 1, 0, 0,     0,     4'b0001, 4'b0000));
    reps.push_back(mk(2, 0, 0, 16,    32,    4'b0000, 4'b0000));
    reps.push_back(mk(2, 1, 0, 0,     0,     4'b0000, 4'b0000));
    reps.push_back(mk(3, 0, 0, 15360, 16384, 4'b0001, 4'b0000));
    reps.push_back(mk(3, 1, 0, 0,     0,     4'b0001, 4'b0000));
    reps.push_back(mk(4, 0, 1, 0,     16,    4'b0010, st(4'b0010)));
    reps.push_back(mk(4, 0, 3, 8,     16,    4'b0010, st(4'b0010)));
    reps.push_back(mk(4, 1, 0, 0,     0,     4'b0010, st(4'b0010)));
    reps.push_back(mk(5, 1, 0, 0,     0,     4'b0000, 4'b0000));
    reps.push_back(mk(6, 0, 0, 16,    16,    4'b0001, 4'b0000));
    reps.push_back(mk(6, 0, 1, 16,    16,    4'b0011, 4'b0000));
    reps.push_back(mk(6, 0, 2, 16,    16,    4'b0111, 4'b0000));
    reps.push_back(mk(6, 0, 3, 16,    16,    4'b1111, 4'b0000));
    reps.push_back(mk(6, 1, 0, 0,     0,     4'b1111, 4'b0000));

    repeat (3) @(negedge clk);
    chk("rst_busy",   bus.Busy_o, 0);
    chk("rst_finish", bus.Finish_o, 0);
    chk("rst_valid",  bus.Ch_valid_o, 0);
    chk("rst_result", bus.Ch_result_o, 0);
    chk("rst_warn",   bus.Ch_warning_o, 0);
    rst_n = 1'b1;

    for (int v = 0; v < NVEC; v++) run_vector(v);

    // Reset in the middle of a COUNT window.
    mi = 11'd1; mul = 5'd1; bus.Ch_en_i = 4'b0001; test_pulse = '1;
    repeat (2) @(negedge clk);
    bus.Start_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("busy_before_reset", bus.Busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",      bus.Busy_o, 0);
    chk("arst_finish",    bus.Finish_o, 0);
    chk("arst_valid",     bus.Ch_valid_o, 0);
    chk("arst_idx",       bus.Ch_idx_o, 0);
    chk("arst_result",    bus.Ch_result_o, 0);
    chk("arst_fullscale", bus.Ch_fullscale_o, 0);
    chk("arst_warn",      bus.Ch_warning_o, 0);
    chk("arst_stuck",     bus.Ch_stuck_o, 0);
    bus.Start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.Finish_o || bus.Ch_valid_o) seen++;
    end
    chk("no_output_after_reset", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
